// File: rtl/mpq_pkg.sv
// mpq_pkg: definitions shared by the max-priority-queue block and its command
// sequencer.
//   - command codes (cmd_code_t, CMD_*)
//   - sequencer state encoding (seq_state_e)
//   - command word layout for the default data width (cmd_word_t)
//   - is_legal_cmd(): true for codes the queue understands
package mpq_pkg;

  typedef logic [2:0] cmd_code_t;

  localparam cmd_code_t CMD_BUILD    = 3'd0;
  localparam cmd_code_t CMD_EXTRACT  = 3'd1;
  localparam cmd_code_t CMD_INCREASE = 3'd2;
  localparam cmd_code_t CMD_INSERT   = 3'd3;
  localparam cmd_code_t CMD_WRITE    = 3'd4;

  localparam int MPQ_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_LOAD        = 3'd0,
    ST_WAIT_IDLE   = 3'd1,
    ST_ISSUE       = 3'd2,
    ST_WAIT_ACCEPT = 3'd3,
    ST_WAIT_DONE   = 3'd4,
    ST_FINISH      = 3'd5
  } seq_state_e;

  typedef struct packed {
    cmd_code_t                 cmd;
    logic [7:0]                index;
    logic [MPQ_DATA_WIDTH-1:0] value;
  } cmd_word_t;

  // Codes above CMD_WRITE are not understood by the queue.
  function automatic logic is_legal_cmd(input cmd_code_t code);
    return (code <= CMD_WRITE);
  endfunction

endpackage

// File: rtl/mpq_cmd_sequencer_if.sv
// mpq_cmd_sequencer_if: sequencer <-> max-priority-queue bus.
//   data_valid/data       : load-burst words towards the queue
//   cmd_valid/cmd/index/value : one-cycle command strobe and its operands
//   busy                  : queue is processing a command
//   done                  : queue finished its write-RAM sequence
// master = sequencer side, slave = queue side.
interface mpq_cmd_sequencer_if
  import mpq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  cmd_valid;
  cmd_code_t             cmd;
  logic [7:0]            index;
  logic [DATA_WIDTH-1:0] value;
  logic                  busy;
  logic                  done;

  modport master (
    output data_valid, data, cmd_valid, cmd, index, value,
    input  busy, done
  );

  modport slave (
    input  data_valid, data, cmd_valid, cmd, index, value,
    output busy, done
  );
endinterface

// File: rtl/mpq_cmd_fifo.sv
// mpq_cmd_fifo: synchronous show-ahead FIFO holding pending command words.
//   clk, rst      : clock, synchronous active-high reset (flushes the FIFO)
//   push, wr_data : write request/word (ignored when full)
//   pop, rd_data  : read request (ignored when empty); rd_data is the head word
//   full, empty   : flags derived from the registered occupancy count
module mpq_cmd_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full    = (count_r == (AW + 1)'(DEPTH));
  assign empty   = (count_r == {(AW + 1){1'b0}});
  assign rd_data = mem_r[rd_ptr_r];

  // Qualify requests against the flags so over/underflow can never occur.
  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
  end

  // Storage array; data words need no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/mpq_cmd_sequencer.sv
// mpq_cmd_sequencer: upstream driver for the max-priority queue.
// Forwards the initial host data burst, buffers host commands and issues them
// one at a time under the queue's busy handshake, then waits for the queue's
// write-RAM completion.
//   clk, rst             : clock, synchronous active-high reset
//   host_data_valid/data : load-burst words from the host
//   host_cmd_valid/cmd/index/value, host_cmd_ready : command push handshake
//   q (master)           : queue bus (data, command strobe, busy, done)
//   all_done             : sticky, write-RAM sequence finished
//   err                  : sticky {timeout, bad_cmd, overflow}
module mpq_cmd_sequencer
  import mpq_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int MAX_DATA       = 32,
  parameter int ACCEPT_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_data_valid,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  host_cmd_valid,
  input  cmd_code_t             host_cmd,
  input  logic [7:0]            host_index,
  input  logic [DATA_WIDTH-1:0] host_value,
  output logic                  host_cmd_ready,
  mpq_cmd_sequencer_if.master   q,
  output logic                  all_done,
  output logic [2:0]            err
);
  localparam int WORD_W = 3 + 8 + DATA_WIDTH;
  localparam int CNT_W  = $clog2(MAX_DATA + 1);

  seq_state_e            state_r;
  logic [CNT_W-1:0]      count_r;
  logic [3:0]            tmo_r;
  logic                  data_valid_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  cmd_valid_r;
  cmd_code_t             cmd_r;
  logic [7:0]            index_r;
  logic [DATA_WIDTH-1:0] value_r;
  logic                  all_done_r;
  logic [2:0]            err_r;

  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [WORD_W-1:0]     head_s;

  // Ready is built only from registered state, so it reflects the FIFO level
  // at the start of the cycle; FINISH freezes the FIFO.
  assign host_cmd_ready = ~fifo_full_s & (state_r != ST_FINISH);

  assign q.data_valid = data_valid_r;
  assign q.data       = data_r;
  assign q.cmd_valid  = cmd_valid_r;
  assign q.cmd        = cmd_r;
  assign q.index      = index_r;
  assign q.value      = value_r;
  assign all_done     = all_done_r;
  assign err          = err_r;

  // Push qualification (illegal codes are consumed but never stored) and pop.
  always_comb begin
    accept_s = host_cmd_valid & host_cmd_ready;
    if (accept_s && is_legal_cmd(host_cmd)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if ((state_r == ST_WAIT_IDLE) && !q.busy && !fifo_empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  mpq_cmd_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .wr_data ({host_cmd, host_index, host_value}),
    .pop     (pop_s),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Sequencer FSM with all queue-facing outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_LOAD;
      count_r      <= {CNT_W{1'b0}};
      tmo_r        <= 4'd0;
      data_valid_r <= 1'b0;
      data_r       <= {DATA_WIDTH{1'b0}};
      cmd_valid_r  <= 1'b0;
      cmd_r        <= CMD_BUILD;
      index_r      <= 8'd0;
      value_r      <= {DATA_WIDTH{1'b0}};
      all_done_r   <= 1'b0;
      err_r        <= 3'b000;
    end else begin
      data_valid_r <= 1'b0;
      cmd_valid_r  <= 1'b0;
      if (accept_s && !is_legal_cmd(host_cmd)) begin
        err_r[1] <= 1'b1;
      end
      case (state_r)
        ST_LOAD: begin
          if (host_data_valid) begin
            if (count_r < CNT_W'(MAX_DATA)) begin
              data_r       <= host_data;
              data_valid_r <= 1'b1;
              count_r      <= count_r + CNT_W'(1);
            end else begin
              err_r[0] <= 1'b1;
            end
          end else if (count_r != {CNT_W{1'b0}}) begin
            state_r <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (pop_s) begin
            {cmd_r, index_r, value_r} <= head_s;
            cmd_valid_r               <= 1'b1;
            state_r                   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Counter holds the ordinal of the current WAIT_ACCEPT cycle.
          tmo_r   <= 4'd1;
          state_r <= ST_WAIT_ACCEPT;
        end
        ST_WAIT_ACCEPT: begin
          if (q.busy) begin
            state_r <= (cmd_r == CMD_WRITE) ? ST_WAIT_DONE : ST_WAIT_IDLE;
          end else if (tmo_r == 4'(ACCEPT_TIMEOUT)) begin
            err_r[2] <= 1'b1;
            state_r  <= ST_WAIT_IDLE;
          end else begin
            tmo_r <= tmo_r + 4'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (q.done) begin
            all_done_r <= 1'b1;
            state_r    <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state_r <= ST_FINISH;
        end
        default: begin
          state_r <= ST_LOAD;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mpq_cmd_sequencer.sv
module tb_mpq_cmd_sequencer;
  import mpq_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          host_data_valid = 1'b0;
  logic [DW-1:0] host_data = 8'd0;
  logic          host_cmd_valid = 1'b0;
  logic [2:0]    host_cmd = 3'd0;
  logic [7:0]    host_index = 8'd0;
  logic [DW-1:0] host_value = 8'd0;
  logic          host_cmd_ready;
  logic          all_done;
  logic [2:0]    err;

  mpq_cmd_sequencer_if #(.DATA_WIDTH(DW)) q ();

  mpq_cmd_sequencer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(8), .MAX_DATA(32), .ACCEPT_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .host_data_valid(host_data_valid), .host_data(host_data),
    .host_cmd_valid(host_cmd_valid), .host_cmd(host_cmd),
    .host_index(host_index), .host_value(host_value),
    .host_cmd_ready(host_cmd_ready),
    .q(q),
    .all_done(all_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue model: reacts to strobes with a short busy window and a done pulse.
  typedef enum int {Q_NORMAL, Q_STALL, Q_DEAD, Q_NODONE} qmode_e;
  qmode_e qmode = Q_DEAD;
  int     qcnt  = 15;

  always @(posedge clk) begin
    #1;
    if (q.cmd_valid === 1'b1) qcnt = 0;
    else if (qcnt < 15) qcnt = qcnt + 1;
    case (qmode)
      Q_STALL:  begin q.busy = 1'b1; q.done = 1'b0; end
      Q_DEAD:   begin q.busy = 1'b0; q.done = 1'b0; end
      Q_NODONE: begin q.busy = (qcnt >= 2 && qcnt < 4); q.done = 1'b0; end
      default:  begin q.busy = (qcnt >= 2 && qcnt < 4); q.done = (qcnt == 6); end
    endcase
  end

  // Scoreboards: expected issued command words and forwarded data words.
  logic [18:0]   exp_q[$];
  logic [DW-1:0] exp_d_q[$];
  int            strobe_cnt = 0;
  int            data_cnt = 0;
  logic          prev_cv = 1'b0;

  always @(negedge clk) begin
    if (q.cmd_valid === 1'b1) begin
      strobe_cnt++;
      chk("strobe_width", 32'(prev_cv), 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_strobe: got cmd %0d idx %0d val %0d, want no strobe",
                 q.cmd, q.index, q.value);
      end else begin
        logic [18:0] w;
        w = exp_q.pop_front();
        chk("issue_word", 32'({q.cmd, q.index, q.value}), 32'(w));
      end
    end
    prev_cv = q.cmd_valid;
    if (q.data_valid === 1'b1) begin
      data_cnt++;
      if (exp_d_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_data: got %0d, want no data_valid", q.data);
      end else begin
        logic [DW-1:0] d;
        d = exp_d_q.pop_front();
        chk("data_word", 32'(q.data), 32'(d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    host_data_valid = 1'b0;
    host_cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_d_q.delete();
  endtask

  task automatic load_one(input logic [7:0] v);
    @(negedge clk);
    host_data_valid = 1'b1;
    host_data = v;
    exp_d_q.push_back(v);
    @(negedge clk);
    host_data_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic [2:0] c, input logic [7:0] idx, input logic [7:0] val,
                      input logic exp_ready);
    @(negedge clk);
    chk("cmd_ready", 32'(host_cmd_ready), 32'(exp_ready));
    host_cmd_valid = 1'b1;
    host_cmd = c;
    host_index = idx;
    host_value = val;
    if (exp_ready && c <= 3'd4) exp_q.push_back({c, idx, val});
    @(negedge clk);
    host_cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_state(input seq_state_e st, input int max_cyc);
    int k;
    k = 0;
    while (dut.state_r != st && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk("reach_state", 32'(dut.state_r), 32'(st));
  endtask

  typedef struct {
    logic       dv;
    logic [7:0] d;
    logic       exp_dv;
    seq_state_e exp_st;
  } load_vec_t;

  load_vec_t lv[6];
  int        s0;
  int        k;

  initial begin
    // Row i: input driven for one cycle, outputs expected one cycle later.
    lv[0] = '{1'b1, 8'd5,  1'b1, ST_LOAD};
    lv[1] = '{1'b1, 8'd3,  1'b1, ST_LOAD};
    lv[2] = '{1'b1, 8'd9,  1'b1, ST_LOAD};
    lv[3] = '{1'b1, 8'd1,  1'b1, ST_LOAD};
    lv[4] = '{1'b0, 8'd0,  1'b0, ST_WAIT_IDLE};
    lv[5] = '{1'b1, 8'd77, 1'b0, ST_WAIT_IDLE};

    // Reset state
    do_reset();
    chk("rst_outs_a", 32'({q.data_valid, q.data, q.cmd_valid, q.cmd, q.index}), 32'd0);
    chk("rst_outs_b", 32'({q.value, all_done, err}), 32'd0);
    chk("rst_ready", 32'(host_cmd_ready), 32'd1);
    chk("rst_state", 32'(dut.state_r), 32'(ST_LOAD));

    // Load burst 5,3,9,1 then a gap; late word ignored
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("load_dv", 32'(q.data_valid), 32'(lv[i-1].exp_dv));
        chk("load_state", 32'(dut.state_r), 32'(lv[i-1].exp_st));
        if (lv[i-1].exp_dv) chk("load_data", 32'(q.data), 32'(lv[i-1].d));
      end
      if (i < 6) begin
        host_data_valid = lv[i].dv;
        host_data = lv[i].d;
        if (lv[i].exp_dv) exp_d_q.push_back(lv[i].d);
      end else begin
        host_data_valid = 1'b0;
      end
    end

    // Build then write while busy; release busy; write completes
    qmode = Q_STALL;
    push(CMD_BUILD, 8'd1, 8'd10, 1'b1);
    push(CMD_WRITE, 8'd0, 8'd0, 1'b1);
    repeat (4) @(negedge clk);
    chk("no_issue_busy", 32'(strobe_cnt), 32'd0);
    qmode = Q_NORMAL;
    @(negedge clk);
    chk("pre_pop_cv", 32'(q.cmd_valid), 32'd0);
    @(negedge clk);
    chk("pop_cv", 32'(q.cmd_valid), 32'd1);
    chk("pop_cmd", 32'(q.cmd), 32'(CMD_BUILD));
    k = 0;
    while (all_done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("all_done", 32'(all_done), 32'd1);
    chk("finish_state", 32'(dut.state_r), 32'(ST_FINISH));
    chk("write_issued", 32'(exp_q.size()), 32'd0);
    push(CMD_EXTRACT, 8'd3, 8'd3, 1'b0);
    repeat (5) @(negedge clk);
    chk("finish_frozen", 32'(strobe_cnt), 32'd2);

    // Nine pushes into an eight-deep FIFO with the queue stalled
    do_reset();
    qmode = Q_STALL;
    load_one(8'd42);
    for (int i = 0; i < 9; i++) begin
      push(3'(i % 4), 8'(i + 20), 8'(i * 3 + 1), (i < 8));
    end
    s0 = strobe_cnt;
    qmode = Q_NORMAL;
    wait_drain(200);
    chk("full_issue_count", 32'(strobe_cnt - s0), 32'd8);
    repeat (12) @(negedge clk);
    chk("done_ignored", 32'(all_done), 32'd0);
    chk("ready_after_drain", 32'(host_cmd_ready), 32'd1);
    chk("err_clean", 32'(err), 32'd0);
    chk("hold_last", 32'({q.cmd, q.index, q.value}), 32'({3'd3, 8'd27, 8'd22}));

    // Illegal code is consumed but never issued
    do_reset();
    qmode = Q_NORMAL;
    load_one(8'd7);
    s0 = strobe_cnt;
    push(3'd6, 8'd1, 8'd1, 1'b1);
    repeat (6) @(negedge clk);
    chk("bad_cmd_err", 32'(err), 32'b010);
    chk("bad_cmd_nostrobe", 32'(strobe_cnt - s0), 32'd0);

    // Queue never accepts: timeout on cycle 15 of WAIT_ACCEPT
    qmode = Q_DEAD;
    push(CMD_EXTRACT, 8'd2, 8'd7, 1'b1);
    k = 0;
    while (q.cmd_valid !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_strobe", 32'(q.cmd_valid), 32'd1);
    repeat (15) @(negedge clk);
    chk("tmo_early", 32'(err[2]), 32'd0);
    @(negedge clk);
    chk("tmo_fire", 32'(err), 32'b110);
    qmode = Q_NORMAL;
    push(CMD_INSERT, 8'd0, 8'd55, 1'b1);
    wait_drain(30);
    chk("tmo_err_sticky", 32'(err), 32'b110);

    // 40-word burst: only 32 forwarded
    do_reset();
    s0 = data_cnt;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      host_data_valid = 1'b1;
      host_data = 8'(i + 1);
      if (i < 32) exp_d_q.push_back(8'(i + 1));
    end
    @(negedge clk);
    host_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("burst_count", 32'(data_cnt - s0), 32'd32);
    chk("burst_err", 32'(err), 32'b001);
    chk("burst_left", 32'(exp_d_q.size()), 32'd0);
    chk("burst_state", 32'(dut.state_r), 32'(ST_WAIT_IDLE));

    // Reset while waiting for done
    do_reset();
    qmode = Q_NODONE;
    load_one(8'd3);
    push(CMD_WRITE, 8'd5, 8'd9, 1'b1);
    wait_state(ST_WAIT_DONE, 30);
    chk("wd_no_done", 32'(all_done), 32'd0);
    chk("wd_cmd_held", 32'({q.cmd, q.index, q.value}), 32'({3'd4, 8'd5, 8'd9}));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outs_a", 32'({q.data_valid, q.data, q.cmd_valid, q.cmd, q.index}), 32'd0);
    chk("abort_outs_b", 32'({q.value, all_done, err}), 32'd0);
    chk("abort_ready", 32'(host_cmd_ready), 32'd1);
    chk("abort_state", 32'(dut.state_r), 32'(ST_LOAD));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
